accel_spi_responder: RTL and testbench

//  SPI responder (slave) emulating the ADXL345 register interface, i.e. the far end of our SPI master.
//  - Sits in the sim harness and the loopback build in place of the G-sensor.
//  - Serves DEVID, the config registers and X/Y/Z sample words supplied on parallel ports.
//  - Raises a DATA_READY interrupt like the real part.
//  - Oversamples SCLK/CS_N/SDI in the system clock domain. SPI mode 3 (CPOL=1, CPHA=1), MSB first.

---
 rtl/accel_resp_pkg.sv | 22 ++
 rtl/spi_resp_sync.sv | 54 +++++
 rtl/accel_spi_responder.sv | 198 +++++++++++++++++++
 tb/tb_accel_spi_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_resp_pkg.sv
// accel_resp_pkg: register map, reset values and FSM states for the ADXL345-style SPI responder
package accel_resp_pkg;
   localparam logic [5:0] ADDR_DEVID       = 6'h00;
   localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
   localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
   localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
   localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
   localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
   localparam logic [5:0] ADDR_DATAX0      = 6'h32;
   localparam logic [5:0] ADDR_DATAX1      = 6'h33;
   localparam logic [5:0] ADDR_DATAY0      = 6'h34;
   localparam logic [5:0] ADDR_DATAY1      = 6'h35;
   localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
   localparam logic [5:0] ADDR_DATAZ1      = 6'h37;
   localparam logic [5:0] ADDR_FIFO_CTL    = 6'h38;
   localparam logic [7:0] BW_RATE_RST_DEF     = 8'h0A;
   localparam logic [7:0] POWER_CTL_RST       = 8'h00;
   localparam logic [7:0] INT_ENABLE_RST      = 8'h00;
   localparam logic [7:0] DATA_FORMAT_RST     = 8'h00;
   localparam logic [7:0] FIFO_CTL_RST        = 8'h00;
   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RD, ST_WR} resp_state_t;
endpackage

// File: rtl/spi_resp_sync.sv
// spi_resp_sync: multi-stage synchronizer for sclk/cs_n/sdi with sclk and cs_n edge pulses
module spi_resp_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sclk,
   input  logic cs_n,
   input  logic sdi,
   output logic cs_n_s,
   output logic sdi_s,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise
);
   logic [SYNC_STAGES-1:0] sclk_q, sclk_d, cs_q, cs_d, sdi_q, sdi_d;
   logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
   logic sclk_s;

   assign sclk_s    = sclk_q[SYNC_STAGES-1];
   assign cs_n_s    = cs_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_fall   = ~cs_n_s & cs_prev_q;
   assign cs_rise   = cs_n_s & ~cs_prev_q;

   // shift the raw pins into the clk domain and remember the last synced level for edge detection
   always_comb begin
      sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_d        = {cs_q[SYNC_STAGES-2:0], cs_n};
      sdi_d       = {sdi_q[SYNC_STAGES-2:0], sdi};
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_n_s;
   end

   // sclk and cs_n reset to their idle-high level so no edge fires out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_q      <= '1;
         cs_q        <= '1;
         sdi_q       <= '0;
         sclk_prev_q <= 1'b1;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_q      <= sclk_d;
         cs_q        <= cs_d;
         sdi_q       <= sdi_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
      end
   end
endmodule

// File: rtl/accel_spi_responder.sv
// accel_spi_responder: ADXL345-style SPI mode-3 register responder; ACCEL_RESP_3WIRE_EN enables 3-wire reads
module accel_spi_responder
   import accel_resp_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DEVID_VAL   = 8'hE5,
   parameter logic [7:0] BW_RATE_RST = BW_RATE_RST_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spi_sclk,
   input  logic        spi_cs_n,
   input  logic        spi_sdi,
   output logic        spi_sdo,
   output logic        spi_sdo_oe,
   output logic        spi_sdi_oe,
   input  logic [15:0] sample_x,
   input  logic [15:0] sample_y,
   input  logic [15:0] sample_z,
   input  logic        sample_valid,
   output logic        measure_en,
   output logic        int1
);
   resp_state_t state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  sh_in_q, sh_in_d, sh_out_q, sh_out_d;
   logic [5:0]  addr_q, addr_d;
   logic        mb_q, mb_d, sdo_q, sdo_d, sdo_oe_q, sdo_oe_d;
   logic [7:0]  bw_rate_q, bw_rate_d, power_ctl_q, power_ctl_d, int_enable_q, int_enable_d;
   logic [7:0]  data_format_q, data_format_d, fifo_ctl_q, fifo_ctl_d;
   logic [47:0] data_q, data_d, pend_data_q, pend_data_d;
   logic        pend_q, pend_d, dr_q, dr_d, int1_q, int1_d;
   logic        cs_n_s, sdi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic [7:0]  byte_in, rd_data;
   logic [5:0]  rd_addr;
   logic        last, we, rd_load, copy, clear, strobe;

   spi_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .reset_n(reset_n), .sclk(spi_sclk), .cs_n(spi_cs_n), .sdi(spi_sdi),
      .cs_n_s(cs_n_s), .sdi_s(sdi_s), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
      .cs_fall(cs_fall), .cs_rise(cs_rise)
   );

   assign byte_in = {sh_in_q[6:0], sdi_s};
   assign last    = sclk_rise && bit_cnt_q == 3'd7;
   assign rd_addr = (state_q == ST_CMD) ? byte_in[5:0] : (mb_q ? addr_q + 6'd1 : addr_q);
   assign rd_load = last && ((state_q == ST_CMD && byte_in[7]) || state_q == ST_RD);
   assign clear   = rd_load && rd_addr >= ADDR_DATAX0 && rd_addr <= ADDR_DATAZ1;
   assign copy    = pend_q && cs_n_s;
   assign strobe  = sample_valid && power_ctl_q[3];

   // register map read mux for the byte about to be loaded into the SDO shifter
   always_comb begin
      rd_data = 8'h00;
      case (rd_addr)
         ADDR_DEVID:       rd_data = DEVID_VAL;
         ADDR_BW_RATE:     rd_data = bw_rate_q;
         ADDR_POWER_CTL:   rd_data = power_ctl_q;
         ADDR_INT_ENABLE:  rd_data = int_enable_q;
         ADDR_INT_SOURCE:  rd_data = {dr_q, 7'd0};
         ADDR_DATA_FORMAT: rd_data = data_format_q;
         ADDR_DATAX0:      rd_data = data_q[7:0];
         ADDR_DATAX1:      rd_data = data_q[15:8];
         ADDR_DATAY0:      rd_data = data_q[23:16];
         ADDR_DATAY1:      rd_data = data_q[31:24];
         ADDR_DATAZ0:      rd_data = data_q[39:32];
         ADDR_DATAZ1:      rd_data = data_q[47:40];
         ADDR_FIFO_CTL:    rd_data = fifo_ctl_q;
         default:          rd_data = 8'h00;
      endcase
   end

   // transaction FSM: command byte, then read shifting on falls or write collection on rises
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sh_in_d   = sh_in_q;
      sh_out_d  = sh_out_q;
      addr_d    = addr_q;
      mb_d      = mb_q;
      sdo_d     = sdo_q;
      sdo_oe_d  = sdo_oe_q;
      we        = 1'b0;
      if (cs_rise) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         sdo_d     = 1'b0;
         sdo_oe_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (cs_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = 3'd0;
            end
            ST_CMD: if (sclk_rise) begin
               sh_in_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (last) begin
                  addr_d   = byte_in[5:0];
                  mb_d     = byte_in[6];
                  state_d  = byte_in[7] ? ST_RD : ST_WR;
                  sh_out_d = byte_in[7] ? rd_data : sh_out_q;
               end
            end
            ST_RD: begin
               if (sclk_fall) begin
                  sdo_d    = sh_out_q[7];
                  sh_out_d = {sh_out_q[6:0], 1'b0};
                  sdo_oe_d = 1'b1;
               end
               if (sclk_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last) begin
                     addr_d   = rd_addr;
                     sh_out_d = rd_data;
                  end
               end
            end
            ST_WR: if (sclk_rise) begin
               sh_in_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (last) begin
                  we     = 1'b1;
                  addr_d = mb_q ? addr_q + 6'd1 : addr_q;
               end
            end
         endcase
      end
   end

   // config writes, sample capture with deferred copy while selected, and DATA_READY/int1
   always_comb begin
      bw_rate_d     = (we && addr_q == ADDR_BW_RATE)     ? byte_in : bw_rate_q;
      power_ctl_d   = (we && addr_q == ADDR_POWER_CTL)   ? byte_in : power_ctl_q;
      int_enable_d  = (we && addr_q == ADDR_INT_ENABLE)  ? byte_in : int_enable_q;
      data_format_d = (we && addr_q == ADDR_DATA_FORMAT) ? byte_in : data_format_q;
      fifo_ctl_d    = (we && addr_q == ADDR_FIFO_CTL)    ? byte_in : fifo_ctl_q;
      pend_data_d   = strobe ? {sample_z, sample_y, sample_x} : pend_data_q;
      pend_d        = strobe ? 1'b1 : (copy ? 1'b0 : pend_q);
      data_d        = copy ? pend_data_q : data_q;
      dr_d          = copy ? 1'b1 : (clear ? 1'b0 : dr_q);
      int1_d        = dr_q & int_enable_q[7];
   end

   // state and register file flops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= 3'd0;
         sh_in_q       <= 8'h00;
         sh_out_q      <= 8'h00;
         addr_q        <= 6'd0;
         mb_q          <= 1'b0;
         sdo_q         <= 1'b0;
         sdo_oe_q      <= 1'b0;
         bw_rate_q     <= BW_RATE_RST;
         power_ctl_q   <= POWER_CTL_RST;
         int_enable_q  <= INT_ENABLE_RST;
         data_format_q <= DATA_FORMAT_RST;
         fifo_ctl_q    <= FIFO_CTL_RST;
         data_q        <= 48'd0;
         pend_data_q   <= 48'd0;
         pend_q        <= 1'b0;
         dr_q          <= 1'b0;
         int1_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         sh_in_q       <= sh_in_d;
         sh_out_q      <= sh_out_d;
         addr_q        <= addr_d;
         mb_q          <= mb_d;
         sdo_q         <= sdo_d;
         sdo_oe_q      <= sdo_oe_d;
         bw_rate_q     <= bw_rate_d;
         power_ctl_q   <= power_ctl_d;
         int_enable_q  <= int_enable_d;
         data_format_q <= data_format_d;
         fifo_ctl_q    <= fifo_ctl_d;
         data_q        <= data_d;
         pend_data_q   <= pend_data_d;
         pend_q        <= pend_d;
         dr_q          <= dr_d;
         int1_q        <= int1_d;
      end
   end

   assign measure_en = power_ctl_q[3];
   assign int1       = int1_q;
   assign spi_sdo    = sdo_q & sdo_oe_q;
`ifdef ACCEL_RESP_3WIRE_EN
   assign spi_sdo_oe = sdo_oe_q & ~data_format_q[6];
   assign spi_sdi_oe = sdo_oe_q & data_format_q[6];
`else
   assign spi_sdo_oe = sdo_oe_q;
   assign spi_sdi_oe = 1'b0;
`endif
endmodule

// File: tb/tb_accel_spi_responder.sv
// tb_accel_spi_responder: directed SPI master with a register-map model of the responder
module tb_accel_spi_responder;
   localparam int H = 6;
   logic clk = 1'b0, reset_n = 1'b0;
   logic spi_sclk = 1'b1, spi_cs_n = 1'b1, spi_sdi = 1'b0;
   logic spi_sdo, spi_sdo_oe, spi_sdi_oe, measure_en, int1;
   logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
   logic sample_valid = 1'b0;
   int n_chk = 0, n_fail = 0;
   logic chk_en = 1'b0;
   logic [7:0] tx [0:15];
   logic [7:0] rx [0:15];
   logic [7:0] exp_rx [0:15];
   logic [7:0] m_reg [0:63];
   logic [47:0] m_data, m_pdata;
   logic m_dr, m_pend;

   accel_spi_responder dut (
      .clk(clk), .reset_n(reset_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_sdi(spi_sdi),
      .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .spi_sdi_oe(spi_sdi_oe),
      .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z), .sample_valid(sample_valid),
      .measure_en(measure_en), .int1(int1)
   );

   always #20 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m3w();
`ifdef ACCEL_RESP_3WIRE_EN
      return m_reg[6'h31][6];
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] m_read(input logic [5:0] a);
      if (a == 6'h00) return 8'hE5;
      if (a == 6'h30) return {m_dr, 7'd0};
      if (a >= 6'h32 && a <= 6'h37) return m_data[8*(a-6'h32) +: 8];
      return m_reg[a];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
      m_reg[6'h2C] = 8'h0A;
      m_data = '0;
      m_pdata = '0;
      m_dr = 1'b0;
      m_pend = 1'b0;
   endtask

   // idle-time compare against the model: outputs that must hold between transactions
   always @(negedge clk) if (chk_en) begin
      check("idle_measure_en", {7'd0, measure_en}, {7'd0, m_reg[6'h2D][3]});
      check("idle_int1", {7'd0, int1}, {7'd0, m_dr & m_reg[6'h2E][7]});
      check("idle_sdo_oe", {7'd0, spi_sdo_oe}, 8'h00);
      check("idle_sdi_oe", {7'd0, spi_sdi_oe}, 8'h00);
      check("idle_sdo", {7'd0, spi_sdo}, 8'h00);
   end

   task automatic spi_bit(input logic bi, output logic so, output logic oe, output logic ioe);
      spi_sdi = bi;
      spi_sclk = 1'b0;
      repeat (H) @(negedge clk);
      so = spi_sdo;
      oe = spi_sdo_oe;
      ioe = spi_sdi_oe;
      spi_sclk = 1'b1;
      repeat (H) @(negedge clk);
   endtask

   task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      logic en;
      en = chk_en;
      chk_en = 1'b0;
      @(negedge clk);
      sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      if (m_reg[6'h2D][3]) begin
         m_pdata = {z, y, x};
         m_pend = 1'b1;
         if (spi_cs_n) begin
            m_data = m_pdata; m_dr = 1'b1; m_pend = 1'b0;
         end
      end
      repeat (5) @(negedge clk);
      chk_en = en;
   endtask

   task automatic xfer(input logic [7:0] cmd, input int nbytes, input int cut);
      logic [5:0] a;
      logic [7:0] sh;
      logic so, oe, ioe;
      int nb, done;
      chk_en = 1'b0;
      a = cmd[5:0];
      if (cmd[7]) for (int i = 0; i <= nbytes; i++) begin
         if (i < nbytes) exp_rx[i] = m_read(a);
         if (a >= 6'h32 && a <= 6'h37) m_dr = 1'b0;
         if (cmd[6]) a = a + 6'd1;
      end
      nb = cut > 0 ? cut : 8 * (nbytes + 1);
      @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (H) @(negedge clk);
      for (int b = 0; b < nb; b++) begin
         if (b < 8) sh = cmd; else sh = tx[b/8-1];
         spi_bit(sh[7 - b % 8], so, oe, ioe);
         if (b < 8 || !cmd[7]) begin
            check("oe_in_cmd_or_wr", {7'd0, oe}, 8'h00);
            check("sdi_oe_in_cmd_or_wr", {7'd0, ioe}, 8'h00);
         end else begin
            rx[b/8-1][7 - b % 8] = so;
            check("oe_in_rd", {7'd0, oe}, {7'd0, ~m3w()});
            check("sdi_oe_in_rd", {7'd0, ioe}, {7'd0, m3w()});
         end
      end
      repeat (H) @(negedge clk);
      spi_cs_n = 1'b1;
      spi_sdi = 1'b0;
      done = nb / 8 - 1;
      a = cmd[5:0];
      for (int i = 0; i < done; i++) begin
         if (cmd[7]) check($sformatf("rd_byte%0d_addr%0h", i, a), rx[i], exp_rx[i]);
         else if (a inside {6'h2C, 6'h2D, 6'h2E, 6'h31, 6'h38}) m_reg[a] = tx[i];
         if (cmd[6]) a = a + 6'd1;
      end
      if (m_pend) begin
         m_data = m_pdata; m_dr = 1'b1; m_pend = 1'b0;
      end
      repeat (10) @(negedge clk);
      chk_en = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic so, oe, ioe;
      logic [7:0] c;
      m_reset();
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_int1", {7'd0, int1}, 8'h00);
      check("rst_measure_en", {7'd0, measure_en}, 8'h00);
      chk_en = 1'b1;
      repeat (4) @(negedge clk);
      // DEVID read, two bytes without MB
      xfer(8'h80, 2, 0);
      check("t1_devid0", rx[0], 8'hE5);
      check("t1_devid1", rx[1], 8'hE5);
      // enable measurement, strobe a sample and burst-read it
      tx[0] = 8'h08;
      xfer(8'h2D, 1, 0);
      check("t2_measure_en", {7'd0, measure_en}, 8'h01);
      strobe(16'h1234, 16'hFF80, 16'h0100);
      xfer(8'hF2, 6, 0);
      check("t2_x0", rx[0], 8'h34);
      check("t2_x1", rx[1], 8'h12);
      check("t2_y0", rx[2], 8'h80);
      check("t2_y1", rx[3], 8'hFF);
      check("t2_z0", rx[4], 8'h00);
      check("t2_z1", rx[5], 8'h01);
      // DATA_READY interrupt set by a strobe, cleared by a DATAX0 read
      tx[0] = 8'h80;
      xfer(8'h2E, 1, 0);
      strobe(16'h1234, 16'hFF80, 16'h0100);
      check("t3_int1_set", {7'd0, int1}, 8'h01);
      xfer(8'hB2, 1, 0);
      check("t3_int1_clr", {7'd0, int1}, 8'h00);
      check("t3_x0_again", rx[0], 8'h34);
      tx[0] = 8'h00;
      xfer(8'h2D, 1, 0);
      strobe(16'h5555, 16'h5555, 16'h5555);
      check("t3_int1_dropped", {7'd0, int1}, 8'h00);
      tx[0] = 8'h08;
      xfer(8'h2D, 1, 0);
      // coherency: strobe mid-burst is deferred until cs_n rises
      strobe(16'h2222, 16'h0000, 16'h0000);
      fork
         xfer(8'hF2, 2, 0);
         begin
            repeat (130) @(negedge clk);
            strobe(16'h1111, 16'h0000, 16'h0000);
         end
      join
      check("t4_old_x0", rx[0], 8'h22);
      check("t4_old_x1", rx[1], 8'h22);
      check("t4_int1_after_copy", {7'd0, int1}, 8'h01);
      xfer(8'hF2, 2, 0);
      check("t4_new_x0", rx[0], 8'h11);
      check("t4_new_x1", rx[1], 8'h11);
      // MB address wrap and aborted partial write
      xfer(8'hFF, 2, 0);
      check("t5_addr3f", rx[0], 8'h00);
      check("t5_wrap_devid", rx[1], 8'hE5);
      tx[0] = 8'h55;
      xfer(8'h2C, 1, 12);
      xfer(8'hAC, 1, 0);
      check("t5_bw_rate_kept", rx[0], 8'h0A);
      // async reset in the middle of a read data byte
      strobe(16'h0001, 16'h0000, 16'h0000);
      check("t6_int1_pre", {7'd0, int1}, 8'h01);
      chk_en = 1'b0;
      c = 8'h80;
      @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (H) @(negedge clk);
      for (int b = 0; b < 8; b++) spi_bit(c[7 - b], so, oe, ioe);
      for (int b = 0; b < 3; b++) spi_bit(1'b0, so, oe, ioe);
      check("t6_oe_pre", {7'd0, oe}, 8'h01);
      #7 reset_n = 1'b0;
      #1;
      check("t6_rst_sdo_oe", {7'd0, spi_sdo_oe}, 8'h00);
      check("t6_rst_int1", {7'd0, int1}, 8'h00);
      check("t6_rst_measure_en", {7'd0, measure_en}, 8'h00);
      spi_cs_n = 1'b1;
      m_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_en = 1'b1;
      xfer(8'hAC, 1, 0);
      check("t6_bw_rate_rst", rx[0], 8'h0A);
      xfer(8'hAD, 1, 0);
      check("t6_power_ctl_rst", rx[0], 8'h00);
`ifdef ACCEL_RESP_3WIRE_EN
      tx[0] = 8'h40;
      xfer(8'h31, 1, 0);
      xfer(8'h80, 1, 0);
      check("t7_3w_devid", rx[0], 8'hE5);
`endif
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
